// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared definitions for the ibuf ring reader (header layout,
// tuser layout, RAM read latency, FSM encoding, skid FIFO entry).
package ibuf_pkg;

    // ibuf RAM returns data this many clocks after the address is presented
    localparam int IBUF_RD_LAT = 2;

    // Header word field positions
    localparam int LEN_LSB = 32;
    localparam int SRC_LSB = 0;
    localparam int DES_LSB = 16;

    // m_axis_tuser field positions; bits above the timestamp are zero
    localparam int TU_LEN_LSB = 0;
    localparam int TU_SRC_LSB = 16;
    localparam int TU_DES_LSB = 24;
    localparam int TU_TS_LSB  = 32;

    // Word count width: ceil(65535/8) = 8192 needs 14 bits
    localparam int NW_W = 14;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_TS     = 3'd2,
        S_DATA   = 3'd3,
        S_COMMIT = 3'd4
    } ibuf_state_e;

    // One skid FIFO entry (73 bits)
    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tstrb;
        logic        tlast;
    } axis_beat_t;

    // Data words in a packet; an empty packet still occupies one word
    function automatic logic [NW_W-1:0] calc_nw(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        calc_nw = (len == 16'd0) ? NW_W'(1) : sum[16:3];
    endfunction

    // Byte enables for the final beat of a packet
    function automatic logic [7:0] last_strb(input logic [15:0] len);
        last_strb = (len[2:0] == 3'd0) ? 8'hFF : 8'((9'd1 << len[2:0]) - 9'd1);
    endfunction

endpackage

// File: rtl/ibuf_rd_skid.sv
// ibuf_rd_skid: small synchronous FIFO of AXIS beats. Absorbs words already
// in flight from the ibuf RAM while the downstream stalls.
module ibuf_rd_skid
    import ibuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  axis_beat_t             din,
    input  logic                   pop,
    output axis_beat_t             dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    axis_beat_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop_ok;
    logic           push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed: contents are only seen when count != 0
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ibuf2axis.sv
// ibuf2axis: walks committed packets in the ibuf ring and streams each one
// out as a 64-bit AXI4-Stream frame, then returns the space by advancing
// committed_cons. Optional timestamp word per packet: IBUF2AXIS_TIMESTAMP_EN.
module ibuf2axis
    import ibuf_pkg::*;
#(
    parameter int BW         = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tstrb,
    output logic [127:0]  m_axis_tuser,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    output logic          busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ibuf_state_e          state, state_nx;
    logic [BW:0]          ptr;          // next word to read
    logic [NW_W-1:0]      nw;
    logic [NW_W-1:0]      words_iss;
    logic [NW_W-1:0]      words_ret;
    logic [15:0]          len_q;
    logic [7:0]           src_q;
    logic [7:0]           des_q;
    logic [63:0]          ts_val;
    logic [IBUF_RD_LAT:1] vld_pipe;     // one bit per outstanding RAM read
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic                 rd_issue;
    logic                 data_issue;
    logic                 hdr_load;
    logic                 data_ret;
    logic                 commit;
    logic                 room;
    logic                 last_hs;
    logic                 beat_hs;
    axis_beat_t           push_beat;
    axis_beat_t           head;
    logic [127:0]         tuser;

`ifdef IBUF2AXIS_TIMESTAMP_EN
    logic                 ts_wait;      // timestamp read already issued
    logic                 ts_load;
    logic [63:0]          ts_q;
    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    // Header reads come from the consumer pointer, everything else from ptr
    assign rd_addr  = (state == S_IDLE) ? committed_cons[BW-1:0] : ptr[BW-1:0];
    assign busy     = (state != S_IDLE);
    assign data_ret = (state == S_DATA) && vld_pipe[IBUF_RD_LAT];
    assign beat_hs  = m_axis_tvalid && m_axis_tready;
    assign last_hs  = beat_hs && head.tlast;

    // Outstanding reads, counted against FIFO space so every return has a slot
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= IBUF_RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    assign room = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);

    // Returned data word, tagged with tlast/tstrb on the packet's final word
    always_comb begin
        push_beat.tdata = rd_data;
        push_beat.tlast = (words_ret == nw - NW_W'(1));
        push_beat.tstrb = push_beat.tlast ? last_strb(len_q) : 8'hFF;
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        state_nx   = state;
        rd_issue   = 1'b0;
        data_issue = 1'b0;
        hdr_load   = 1'b0;
        commit     = 1'b0;
`ifdef IBUF2AXIS_TIMESTAMP_EN
        ts_load    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (en && (committed_cons != committed_prod)) begin
                    rd_issue = 1'b1;
                    state_nx = S_HDR;
                end
            end
            S_HDR: begin
                if (vld_pipe[IBUF_RD_LAT]) begin
                    hdr_load = 1'b1;
`ifdef IBUF2AXIS_TIMESTAMP_EN
                    state_nx = S_TS;
`else
                    state_nx = S_DATA;
`endif
                end
            end
`ifdef IBUF2AXIS_TIMESTAMP_EN
            S_TS: begin
                if (!ts_wait) begin
                    rd_issue = 1'b1;
                end else if (vld_pipe[IBUF_RD_LAT]) begin
                    ts_load  = 1'b1;
                    state_nx = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (room && (words_iss < nw)) begin
                    rd_issue   = 1'b1;
                    data_issue = 1'b1;
                end
                // Space is only released after the final beat has gone out
                if (last_hs) state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                commit   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, read tracking, packet context and consumer pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vld_pipe       <= '0;
            ptr            <= '0;
            nw             <= '0;
            words_iss      <= '0;
            words_ret      <= '0;
            len_q          <= '0;
            src_q          <= '0;
            des_q          <= '0;
            committed_cons <= '0;
`ifdef IBUF2AXIS_TIMESTAMP_EN
            ts_wait        <= 1'b0;
            ts_q           <= '0;
`endif
        end else begin
            state    <= state_nx;
            vld_pipe <= {vld_pipe[IBUF_RD_LAT-1:1], rd_issue};
            if (hdr_load) begin
                len_q     <= rd_data[LEN_LSB +: 16];
                src_q     <= rd_data[SRC_LSB +: 8];
                des_q     <= rd_data[DES_LSB +: 8];
                nw        <= calc_nw(rd_data[LEN_LSB +: 16]);
                ptr       <= committed_cons + (BW+1)'(1);
                words_iss <= '0;
                words_ret <= '0;
            end
`ifdef IBUF2AXIS_TIMESTAMP_EN
            if ((state == S_TS) && !ts_wait) ts_wait <= 1'b1;
            if (ts_load) begin
                ts_q    <= rd_data;
                ptr     <= ptr + (BW+1)'(1);
                ts_wait <= 1'b0;
            end
`endif
            if (data_issue) begin
                ptr       <= ptr + (BW+1)'(1);
                words_iss <= words_iss + NW_W'(1);
            end
            if (data_ret) words_ret <= words_ret + NW_W'(1);
            // ptr now points at the next header slot
            if (commit) committed_cons <= ptr;
        end
    end

    // Per-packet sideband, constant across every beat of the frame
    always_comb begin
        tuser = '0;
        tuser[TU_LEN_LSB +: 16] = len_q;
        tuser[TU_SRC_LSB +: 8]  = src_q;
        tuser[TU_DES_LSB +: 8]  = des_q;
        tuser[TU_TS_LSB  +: 64] = ts_val;
    end

    ibuf_rd_skid #(
        .DEPTH (FIFO_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (data_ret),
        .din   (push_beat),
        .pop   (beat_hs),
        .dout  (head),
        .count (fifo_count)
    );

    // Payload is forced to zero whenever no beat is presented
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head.tdata : '0;
    assign m_axis_tstrb  = m_axis_tvalid ? head.tstrb : '0;
    assign m_axis_tlast  = m_axis_tvalid && head.tlast;
    assign m_axis_tuser  = m_axis_tvalid ? tuser : '0;

endmodule

// File: tb/tb_ibuf2axis.sv
// tb_ibuf2axis: randomized packet traffic through a behavioural ibuf ring
// with 2-cycle read latency; expected frames are derived from the packet
// format rules and compared beat by beat.
module tb_ibuf2axis;
    localparam int BW   = 10;
    localparam int RING = 1 << BW;
`ifdef IBUF2AXIS_TIMESTAMP_EN
    localparam int TS_WORDS = 1;
`else
    localparam int TS_WORDS = 0;
`endif

    typedef struct packed {
        logic [63:0]  d;
        logic [7:0]   s;
        logic         l;
        logic [127:0] u;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [BW:0]   committed_prod;
    logic [BW:0]   committed_cons;
    logic [BW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tstrb;
    logic [127:0]  m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    int            rdy_mode = 0;
    logic [BW:0]   wr_ptr;
    logic [63:0]   mem [RING];
    logic [63:0]   p1;
    beat_t         exp_q[$];
    beat_t         obs_q[$];
    int            stab_err = 0;
    int            vld_seen = 0;
    logic          pend_v = 1'b0;
    logic [63:0]   pend_d = '0;

    always #5 clk = ~clk;

    ibuf2axis #(.BW(BW), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .committed_prod (committed_prod),
        .committed_cons (committed_cons),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy)
    );

    // ibuf RAM: data appears two clocks after the address
    always @(posedge clk) begin
        p1      <= mem[rd_addr];
        rd_data <= p1;
    end

    // Capture handshaked beats; flag a presented beat that drops or changes
    always @(negedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
        end else begin
            if (pend_v && (!m_axis_tvalid || (m_axis_tdata !== pend_d))) stab_err <= stab_err + 1;
            if (m_axis_tvalid) vld_seen <= vld_seen + 1;
            if (m_axis_tvalid && m_axis_tready)
                obs_q.push_back({m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser});
            pend_v <= m_axis_tvalid && !m_axis_tready;
            pend_d <= m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    // Writer model: lay a packet into the ring and queue its expected beats
    task automatic write_pkt(input int len, input logic [7:0] src, input logic [7:0] des);
        int           nw;
        logic [63:0]  ts;
        logic [63:0]  d;
        logic [7:0]   ls;
        logic [127:0] u;
        mem[wr_ptr[BW-1:0]] = {16'h0, 16'(len), 8'h0, des, 8'h0, src};
        wr_ptr = wr_ptr + 1'b1;
        ts = 64'h0;
`ifdef IBUF2AXIS_TIMESTAMP_EN
        ts = {$urandom, $urandom};
        mem[wr_ptr[BW-1:0]] = ts;
        wr_ptr = wr_ptr + 1'b1;
`endif
        nw = (len == 0) ? 1 : (len + 7) / 8;
        ls = (len % 8 == 0) ? 8'hFF : 8'((1 << (len % 8)) - 1);
        u  = {32'h0, ts, des, src, 16'(len)};
        for (int i = 0; i < nw; i++) begin
            d = {$urandom, $urandom};
            mem[wr_ptr[BW-1:0]] = d;
            wr_ptr = wr_ptr + 1'b1;
            exp_q.push_back({d, (i == nw - 1) ? ls : 8'hFF, (i == nw - 1), u});
        end
    endtask

    // Drain expected frames and confirm the consumer pointer catches up
    task automatic check_frames(input string name);
        int    n;
        int    waited;
        int    shown;
        beat_t o;
        beat_t e;
        n = exp_q.size();
        waited = 0;
        shown = 0;
        while (obs_q.size() < n && waited < 4000 + 4 * n) begin
            tick();
            waited++;
        end
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL %s beat_count: got %0d want %0d", name, obs_q.size(), n);
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                if (shown < 8)
                    $display("FAIL %s beat: got d=%h s=%h l=%b u=%h want d=%h s=%h l=%b u=%h",
                             name, o.d, o.s, o.l, o.u, e.d, e.s, e.l, e.u);
                shown++;
            end
        end
        exp_q.delete();
        waited = 0;
        while (committed_cons !== wr_ptr && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (committed_cons !== wr_ptr) begin
            errors++;
            $display("FAIL %s committed_cons: got %h want %h", name, committed_cons, wr_ptr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        committed_prod = '0;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        wr_ptr = '0;
        for (int i = 0; i < RING; i++) mem[i] = '0;
        repeat (3) tick();
        checks++;
        if ({committed_cons, rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
             m_axis_tstrb, m_axis_tuser, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cons=%h addr=%h vld=%b last=%b data=%h strb=%h user=%h busy=%b want all 0",
                     committed_cons, rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                     m_axis_tstrb, m_axis_tuser, busy);
        end
        rst = 1'b0;
        en = 1'b1;
        repeat (4) tick();
        checks++;
        if ({m_axis_tvalid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL empty_ring_idle: vld=%b busy=%b want 0 0", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_single();
        write_pkt(64, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        check_frames("single_len64");
        checks++;
        if (committed_cons !== 11'(9 + TS_WORDS)) begin
            errors++;
            $display("FAIL single_cons: got %h want %h", committed_cons, 11'(9 + TS_WORDS));
        end
    endtask

    task automatic test_short();
        logic [BW:0] c0;
        c0 = committed_cons;
        write_pkt(13, 8'd3, 8'd5);
        committed_prod = wr_ptr;
        check_frames("short_len13");
        checks++;
        if (committed_cons !== c0 + 11'(3 + TS_WORDS)) begin
            errors++;
            $display("FAIL short_cons_step: got %h want %h", committed_cons, c0 + 11'(3 + TS_WORDS));
        end
    endtask

    task automatic test_wrap();
        int pad_nw;
        pad_nw = 1022 - int'(wr_ptr) - 1 - TS_WORDS;
        write_pkt(pad_nw * 8, 8'($urandom), 8'($urandom));
        write_pkt(24, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        check_frames("wrap");
        checks++;
        if (committed_cons !== 11'(11'h402 + TS_WORDS)) begin
            errors++;
            $display("FAIL wrap_cons: got %h want %h", committed_cons, 11'(11'h402 + TS_WORDS));
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = stab_err;
        rdy_mode = 1;
        write_pkt(80, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        check_frames("bp_toggle");
        checks++;
        if (stab_err !== base) begin
            errors++;
            $display("FAIL bp_tvalid_hold: got %0d violations want 0", stab_err - base);
        end
        rdy_mode = 0;
    endtask

    task automatic test_random();
        int base;
        base = stab_err;
        rdy_mode = 2;
        write_pkt(0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2; i++) write_pkt($urandom_range(0, 100), 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        repeat (7) tick();
        for (int i = 0; i < 3; i++) write_pkt($urandom_range(1, 100), 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        check_frames("random");
        checks++;
        if (stab_err !== base) begin
            errors++;
            $display("FAIL random_tvalid_hold: got %0d violations want 0", stab_err - base);
        end
        rdy_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [BW:0] exp_c[$];
        logic [BW:0] last_c;
        int          idle_run;
        int          max_idle;
        int          waited;
        bit          started;
        for (int i = 0; i < 3; i++) begin
            write_pkt($urandom_range(1, 40), 8'($urandom), 8'($urandom));
            exp_c.push_back(wr_ptr);
        end
        committed_prod = wr_ptr;
        last_c = committed_cons;
        idle_run = 0;
        max_idle = 0;
        started = 0;
        waited = 0;
        while (committed_cons !== wr_ptr && waited < 2000) begin
            tick();
            waited++;
            if (committed_cons !== last_c) begin
                checks++;
                if (exp_c.size() == 0 || committed_cons !== exp_c[0]) begin
                    errors++;
                    $display("FAIL b2b_cons_step: got %h want %h", committed_cons,
                             (exp_c.size() != 0) ? exp_c[0] : last_c);
                end
                if (exp_c.size() != 0) void'(exp_c.pop_front());
                last_c = committed_cons;
            end
            if (committed_cons !== wr_ptr) begin
                if (busy) begin
                    started = 1;
                    idle_run = 0;
                end else if (started) begin
                    idle_run++;
                    if (idle_run > max_idle) max_idle = idle_run;
                end
            end
        end
        checks++;
        if (max_idle > 1) begin
            errors++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles want <=1", max_idle);
        end
        checks++;
        if (exp_c.size() != 0) begin
            errors++;
            $display("FAIL b2b_commits: got %0d missing commits want 0", exp_c.size());
        end
        check_frames("b2b");
    endtask

    task automatic test_enable();
        int          base;
        logic [BW:0] c0;
        en = 1'b0;
        base = vld_seen;
        c0 = committed_cons;
        write_pkt(32, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        repeat (20) tick();
        checks++;
        if (vld_seen !== base) begin
            errors++;
            $display("FAIL en0_tvalid: got %0d valid cycles want 0", vld_seen - base);
        end
        checks++;
        if (committed_cons !== c0) begin
            errors++;
            $display("FAIL en0_cons: got %h want %h", committed_cons, c0);
        end
        en = 1'b1;
        check_frames("en_resume");
    endtask

    task automatic test_mid_reset();
        int waited;
        rdy_mode = 3;
        m_axis_tready = 1'b0;
        write_pkt(64, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        waited = 0;
        while (!m_axis_tvalid && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_start: got tvalid=%b want 1", m_axis_tvalid);
        end
        rst = 1'b1;
        committed_prod = '0;
        tick();
        checks++;
        if ({committed_cons, rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
             m_axis_tstrb, m_axis_tuser, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: cons=%h addr=%h vld=%b last=%b data=%h strb=%h user=%h busy=%b want all 0",
                     committed_cons, rd_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                     m_axis_tstrb, m_axis_tuser, busy);
        end
        rst = 1'b0;
        rdy_mode = 0;
        wr_ptr = '0;
        exp_q.delete();
        obs_q.delete();
        tick();
        write_pkt(21, 8'($urandom), 8'($urandom));
        committed_prod = wr_ptr;
        check_frames("post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_short();
        test_wrap();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_enable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
